// File: rtl/mt32_pkg.sv
// MT19937 constants, index helper and controller state encoding,
// shared by the generator and its tempering stage.
package mt32_pkg;

   localparam int N = 624;
   localparam int M = 397;

   localparam logic [31:0] MATRIX_A   = 32'h9908_B0DF;
   localparam logic [31:0] UPPER_MASK = 32'h8000_0000;
   localparam logic [31:0] TEMPER_B   = 32'h9D2C_5680;
   localparam logic [31:0] TEMPER_C   = 32'hEFC6_0000;

   localparam logic [9:0] IDX_LAST = 10'(N - 1);
   localparam logic [9:0] IDX_M    = 10'(M);

   typedef enum logic [2:0] {
      IDLE,
      PRIME,
      PH0,
      PH1,
      PH2,
      PH3
   } mt32_state_e;

   function automatic logic [9:0] idx_inc(input logic [9:0] x);
      return (x == IDX_LAST) ? 10'd0 : x + 10'd1;
   endfunction

endpackage

// File: rtl/mt32_temper.sv
// MT19937 output tempering, purely combinational.
// Reused by every generator variant that shares the package.
module mt32_temper
   import mt32_pkg::*;
(
   input  logic [31:0] word,
   output logic [31:0] tempered
);

   logic [31:0] y1;
   logic [31:0] y2;
   logic [31:0] y3;

   assign y1       = word ^ (word >> 11);
   assign y2       = y1 ^ ((y1 << 7) & TEMPER_B);
   assign y3       = y2 ^ ((y2 << 15) & TEMPER_C);
   assign tempered = y3 ^ (y3 >> 18);

endmodule

// File: rtl/mt32_gen.sv
// MT19937 generator: rewrites the external state RAM in place,
// one word every four cycles, with a valid/ready output slot.
module mt32_gen
   import mt32_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        init,
   input  logic        start,
   output logic [9:0]  raddr,
   input  logic [31:0] rdata,
   output logic [9:0]  waddr,
   output logic        wen,
   output logic [31:0] wdata,
   output logic [31:0] rand_data,
   output logic        rand_valid,
   input  logic        rand_ready,
   output logic        busy
);

   mt32_state_e state;
   mt32_state_e state_n;

   logic [9:0]  i;
   logic [9:0]  k;
   logic [9:0]  j;
   logic [31:0] cur_reg;
   logic [31:0] next_reg;
   logic [31:0] twist_reg;
   logic        from_prime;

   logic [31:0] y;
   logic [31:0] mixed;
   logic [31:0] tempered;
   logic        slot_free;
   logic        advance;

   assign y = (cur_reg & UPPER_MASK) | (next_reg & ~UPPER_MASK);
   assign mixed = rdata ^ (y >> 1) ^ (y[0] ? MATRIX_A : 32'd0);

   assign slot_free = !rand_valid || rand_ready;
   assign advance   = (state == PH3) && slot_free && !init;
   assign busy      = (state != IDLE);

   mt32_temper u_temper (
      .word     (twist_reg),
      .tempered (tempered)
   );

   always_comb begin
      state_n = state;
      raddr   = 10'd0;
      waddr   = 10'd0;
      wen     = 1'b0;
      wdata   = 32'd0;
      case (state)
         IDLE:  if (start) state_n = PRIME;
         PRIME: state_n = PH0;
         PH0: begin
            raddr   = k;
            state_n = PH1;
         end
         PH1: begin
            raddr   = j;
            state_n = PH2;
         end
         PH2: begin
            wen     = 1'b1;
            waddr   = i;
            wdata   = mixed;
            state_n = PH3;
         end
         PH3:     if (slot_free) state_n = PH0;
         default: state_n = IDLE;
      endcase
      // re-seeding owns the RAM: never write behind the initializer
      if (init) begin
         state_n = IDLE;
         wen     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         i          <= 10'd0;
         k          <= 10'd1;
         j          <= IDX_M;
         cur_reg    <= 32'd0;
         next_reg   <= 32'd0;
         twist_reg  <= 32'd0;
         rand_data  <= 32'd0;
         rand_valid <= 1'b0;
         from_prime <= 1'b0;
      end else if (init) begin
         state      <= IDLE;
         i          <= 10'd0;
         k          <= 10'd1;
         j          <= IDX_M;
         rand_valid <= 1'b0;
         from_prime <= 1'b0;
      end else begin
         state      <= state_n;
         from_prime <= (state == PRIME);
         if (state == IDLE) begin
            i <= 10'd0;
            k <= 10'd1;
            j <= IDX_M;
         end
         // mt[0] arrives only once; later words inherit next_reg
         if (state == PH0 && from_prime) cur_reg <= rdata;
         if (state == PH1) next_reg <= rdata;
         if (state == PH2) twist_reg <= mixed;
         if (advance) begin
            rand_data  <= tempered;
            rand_valid <= 1'b1;
            cur_reg    <= next_reg;
            i          <= idx_inc(i);
            k          <= idx_inc(k);
            j          <= idx_inc(j);
         end else if (rand_valid && rand_ready) begin
            rand_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/mt32_gen.md
MT32_GEN -- requirements
Module: mt32_gen

Interface
REQ-001 Parameters: none; all MT19937 constants come from the shared package.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 init  in  1  state RAM being re-seeded; abort and return to IDLE.
REQ-005 start  in  1  single-cycle pulse; begin generation (state RAM already initialised).
REQ-006 raddr  out  10  state RAM read address; RAM returns data one cycle later.
REQ-007 rdata  in  32  state RAM read data for the raddr of the previous cycle.
REQ-008 waddr  out  10  state RAM write address.
REQ-009 wen  out  1  state RAM write enable.
REQ-010 wdata  out  32  state RAM write data.
REQ-011 rand_data  out  32  tempered random word.
REQ-012 rand_valid  out  1  rand_data holds an unconsumed word.
REQ-013 rand_ready  in  1  consumer accepts rand_data when rand_valid && rand_ready.
REQ-014 busy  out  1  high in every state except IDLE.

Function
REQ-015 States: IDLE, PRIME, PH0, PH1, PH2, PH3.
REQ-016 Transitions: IDLE->PRIME on start; PRIME->PH0->PH1->PH2->PH3; PH3->PH0 when the output slot is free (rand_valid low or rand_ready high); otherwise stay in PH3.
REQ-017 init high overrides everything: next state IDLE, indices cleared, rand_valid cleared; start in IDLE while init is high is ignored.
REQ-018 Indices: i, k=(i+1) mod 624, j=(i+397) mod 624; each is a 10-bit counter that wraps 623->0; IDLE sets i=0, k=1, j=397.
REQ-019 PRIME: raddr=0. PH0: raddr=k, cur_reg<=rdata (PRIME only). PH1: raddr=j, next_reg<=rdata.
REQ-020 PH2: y={cur_reg[31], next_reg[30:0]}; new=rdata ^ (y>>1) ^ (y[0] ? 0x9908B0DF : 0); wen=1, waddr=i, wdata=new; twist_reg<=new.
REQ-021 PH3 on advance: rand_data<=temper(twist_reg), rand_valid<=1, cur_reg<=next_reg, and i, k, j all increment with wrap.
REQ-022 Tempering: y^=y>>11; y^=(y<<7)&0x9D2C5680; y^=(y<<15)&0xEFC60000; y^=y>>18; all arithmetic modulo 2^32.
REQ-023 rand_valid clears on a handshake unless a new word loads in the same cycle; rand_data is stable while rand_valid && !rand_ready.
REQ-024 The in-place update order is exact MT19937: for i>=227, j reads already-rewritten entries; at i=623, k=0 reads the rewritten mt[0].
REQ-025 Throughput is one word per 4 cycles with rand_ready held high. The first rand_valid rises at the 5th rising edge after the edge that samples start.
REQ-026 wen is high only in PH2; raddr is don't-care outside PRIME, PH0 and PH1.
REQ-027 start while busy is ignored.

Reset
REQ-028 On reset_n low: state=IDLE, i=0, k=1, j=397, all data registers 0, rand_valid=0, wen=0, busy=0, raddr=0, waddr=0, wdata=0.
REQ-029 Reset asserted mid-operation takes effect immediately. No partial word is presented after reset_n deasserts.

Structure
REQ-030 Package mt32_pkg holds N=624, M=397, MATRIX_A=0x9908B0DF, UPPER_MASK=0x80000000, TEMPER_B=0x9D2C5680, TEMPER_C=0xEFC60000 and the state enum.
REQ-031 Tempering is a combinational sub-module, mt32_temper (32-bit in, 32-bit out); it is shared with future generator variants.

Verification
REQ-032 Seed 5489 via initializer, then start, rand_ready=1 -> first outputs 3499211612, 581869302, 3890346734, 3586334585, 545404204.
REQ-033 Seed 5489, run continuously -> the 10000th output equals 4123659995, which checks both 624-word wrap boundaries.
REQ-034 Backpressure: hold rand_ready=0 for 20 cycles after the first valid word -> rand_data is held at 3499211612, exactly one wen pulse beyond PH2 of word 2 occurs, and no words are lost on release.
REQ-035 Assert init during PH1 of word 300 -> next cycle is IDLE, rand_valid=0, wen=0; re-seed with 5489 and start -> first output is 3499211612 again.
REQ-036 Pulse reset_n low during PH2 -> all outputs are at reset values immediately; start after release -> the sequence restarts from i=0.
